// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers them in a small prefetch queue
// and presents them to decode. Optional same-cycle bypass is enabled with IFQ_BYPASS_EN.
module fetch_unit #(
    parameter int              XLEN     = 16,
    parameter int              ILEN     = 16,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic [ILEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            halted,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic            halted_q, halted_d;
    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [ILEN-1:0] instr_mem_d [DEPTH];
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_d [DEPTH];

    logic commit, bypass, enq, deq, q_empty;

    // Request and decode-valid are gated by rst so both read 0 while reset is held.
    always_comb begin
        q_empty   = (occ_q == '0);
        imem_req  = !rst && !halted_q && !halt && !redirect_valid && (occ_q < CW'(DEPTH));
        imem_addr = pc_q;
        commit    = imem_req && imem_gnt;
`ifdef IFQ_BYPASS_EN
        bypass    = commit && q_empty && dec_ready;
`else
        bypass    = 1'b0;
`endif
        dec_valid = !rst && !redirect_valid && (!q_empty || bypass);
        deq       = dec_valid && dec_ready && !q_empty;
        enq       = commit && !bypass;
        dec_instr = '0;
        dec_pc    = '0;
        if (dec_valid) begin
            if (bypass) begin
                dec_instr = imem_data;
                dec_pc    = pc_q;
            end else begin
                dec_instr = instr_mem_q[rd_ptr_q];
                dec_pc    = pc_mem_q[rd_ptr_q];
            end
        end
        halted    = halted_q;
        occupancy = occ_q;
    end

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        halted_d    = halted_q || halt;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (commit) begin
                pc_d = pc_q + XLEN'(PC_STEP);
            end
            if (enq) begin
                instr_mem_d[wr_ptr_q] = imem_data;
                pc_mem_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occ_d = occ_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset: entries are only visible while occupancy covers them.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic, all compared
// against a queue-based reference model of the fetch/decode behaviour.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        halted;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    bit          m_halted;

    fetch_unit #(.XLEN(16), .ILEN(16), .DEPTH(DEPTH), .PC_STEP(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .halted(halted), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Asserts reset asynchronously (caller is at a falling edge), checks the immediate clear.
    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
        halt = 1'b0; dec_ready = 1'b0;
        mq.delete();
        m_pc = 16'h0000;
        m_halted = 1'b0;
        #1;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_dec_instr", 32'(dec_instr), 0);
        chk("rst_dec_pc", 32'(dec_pc), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_halted", 32'(halted), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model, cross the edge.
    task automatic cycle(input bit g, input bit r, input bit rv, input logic [15:0] rpc,
                         input bit h, input logic [15:0] d);
        int   n;
        bit   e_req, e_byp, e_valid;
        ent_t e_out;
        imem_gnt = g; dec_ready = r; redirect_valid = rv; redirect_pc = rpc; halt = h;
        imem_data = d;
        #1;
        n       = mq.size();
        e_req   = !m_halted && !h && !rv && (n < DEPTH);
        e_byp   = 1'b0;
`ifdef IFQ_BYPASS_EN
        e_byp   = e_req && g && (n == 0) && r;
`endif
        e_valid = !rv && (n > 0 || e_byp);
        e_out   = '0;
        if (e_valid) e_out = e_byp ? ent_t'{pc: m_pc, instr: d} : mq[0];
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("dec_valid", 32'(dec_valid), 32'(e_valid));
        chk("dec_instr", 32'(dec_instr), 32'(e_out.instr));
        chk("dec_pc", 32'(dec_pc), 32'(e_out.pc));
        chk("occupancy", 32'(occupancy), 32'(n));
        chk("halted", 32'(halted), 32'(m_halted));
        if (rv) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            if (e_valid && r && n > 0) void'(mq.pop_front());
            if (e_req && g) begin
                if (!e_byp) mq.push_back(ent_t'{pc: m_pc, instr: d});
                m_pc = m_pc + 16'd2;
            end
        end
        if (h) m_halted = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0; imem_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
        halt = 1'b0; dec_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming with decode always ready: one-cycle latency, queue never above 1.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 0, 16'h0, 0, m_pc ^ 16'hA000);
`ifndef IFQ_BYPASS_EN
            if (k < 4) chk("stream_pc", 32'(dec_pc), 32'(2 * k));
            chk("stream_occ_le1", 32'(occupancy <= 3'd1), 1);
`endif
        end

        // Decode stall fills the queue, then drains in order.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(1, 0, 0, 16'h0, 0, $urandom_range(16'hFFFF));
`ifndef IFQ_BYPASS_EN
            chk("stall_occ", 32'(occupancy), (k < 3) ? k + 1 : 4);
            chk("stall_pc_held", 32'(dec_pc), 0);
`endif
        end
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 16'h0, 0, 16'h0);

        // Redirect with three queued entries.
        do_reset();
        repeat (3) cycle(1, 0, 0, 16'h0, 0, $urandom_range(16'hFFFF));
        cycle(1, 1, 1, 16'h0100, 0, 16'h5555);
        chk("redir_occ", 32'(occupancy), 0);
        chk("redir_addr", 32'(imem_addr), 32'h0100);

        // PC wrap at the top of the address space.
        cycle(0, 0, 1, 16'hFFFE, 0, 16'h0);
        cycle(1, 0, 0, 16'h0, 0, 16'hBEEF);
        chk("wrap_addr", 32'(imem_addr), 0);
        chk("wrap_dec_pc", 32'(dec_pc), 32'hFFFE);
        repeat (2) cycle(0, 1, 0, 16'h0, 0, 16'h0);

        // Halt with two entries queued: they still drain, then nothing more.
        do_reset();
        repeat (2) cycle(1, 0, 0, 16'h0, 0, $urandom_range(16'hFFFF));
        cycle(1, 0, 0, 16'h0, 1, 16'h1111);
        chk("halt_sticky", 32'(halted), 1);
        repeat (4) cycle(1, 1, 0, 16'h0, 0, $urandom_range(16'hFFFF));
        chk("halt_drained", 32'(dec_valid), 0);
        chk("halt_no_req", 32'(imem_req), 0);
        do_reset();
        chk("halt_cleared", 32'(halted), 0);

        // Mid-operation reset drops queued entries at once.
        repeat (3) cycle(1, 0, 0, 16'h0, 0, $urandom_range(16'hFFFF));
        do_reset();
        cycle(1, 1, 0, 16'h0, 0, 16'h2222);

        // Random traffic in several segments.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(3) != 0, $urandom_range(4) > 1, $urandom_range(19) == 0,
                      16'($urandom_range(16'hFFFF)), $urandom_range(99) == 0,
                      16'($urandom_range(16'hFFFF)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
